border_pixel_mux: RTL and testbench

Output-side consumer of the border unit's `main_border`/`vborder` flags. Delays the flag and the border colour register (`ec`) to align with the graphics/sprite pixel stream, then substitutes `ec` for the pixel colour while the border is active. It also accumulates per-frame statistics of opened borders (side and top/bottom) for the register file and debug readback.

---
 rtl/border_pixel_mux.sv | 129 ++++++++++++
 tb/tb_border_pixel_mux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/border_pixel_mux.sv
// border_pixel_mux
//   Aligns the border flag and border colour with the pixel stream, then
//   replaces the pixel colour with the border colour while the delayed border
//   flag is set. Also counts, per frame, the lines whose side border was
//   fully open and the lines whose vertical border was open on any dot.
//
// Ports
//   clk_dot4x        4x dot clock
//   rst              synchronous active-high reset
//   dot_rising       one-cycle pulse per dot; all state advances only then
//   main_border      main border flag
//   vborder          vertical border flag
//   ec               border colour
//   pixel_color_in   graphics/sprite colour, already aligned to output
//   new_line         first dot of a raster line (qualified by dot_rising)
//   new_frame        first dot of a frame (qualified by dot_rising)
//   pixel_color_out  final pixel colour
//   border_active    delayed main_border, as used by the mux
//   open_side_lines  side-open line count of the last completed frame
//   open_vert_lines  vertical-open line count of the last completed frame
//
// PIPE_DEPTH (1..4) is the dot delay from main_border/ec to the outputs.

module border_pixel_mux #(
    parameter int PIPE_DEPTH = 2
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic       dot_rising,
    input  logic       main_border,
    input  logic       vborder,
    input  logic [3:0] ec,
    input  logic [3:0] pixel_color_in,
    input  logic       new_line,
    input  logic       new_frame,
    output logic [3:0] pixel_color_out,
    output logic       border_active,
    output logic [8:0] open_side_lines,
    output logic [8:0] open_vert_lines
);

    typedef struct packed {
        logic       border;
        logic [3:0] ec;
    } stage_t;

    localparam logic [8:0] CNT_MAX = 9'd511;

    // Border flag and colour travel together so a colour change mid-border
    // lands on exactly the same dot as a border edge would.
    stage_t [PIPE_DEPTH-1:0] dly;

    logic       line_has_dots;
    logic       line_mb_seen;
    logic       line_vb_open;
    logic [8:0] side_cnt;
    logic [8:0] vert_cnt;

    logic       line_start;
    logic       side_inc;
    logic       vert_inc;
    logic [8:0] side_next;
    logic [8:0] vert_next;

    // The delay line feeds one output register, so the last stage is read
    // directly: a sample taken at dot n reaches the outputs at dot n+PIPE_DEPTH.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                dly[i].border <= 1'b1;
                dly[i].ec     <= 4'd0;
            end
            pixel_color_out <= 4'd0;
            border_active   <= 1'b1;
        end else if (dot_rising) begin
            dly[0].border <= main_border;
            dly[0].ec     <= ec;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                dly[i] <= dly[i-1];
            end
            border_active   <= dly[PIPE_DEPTH-1].border;
            pixel_color_out <= dly[PIPE_DEPTH-1].border ? dly[PIPE_DEPTH-1].ec
                                                        : pixel_color_in;
        end
    end

    // new_frame alone still closes the line it interrupts.
    always_comb begin
        line_start = new_line | new_frame;
        side_inc   = line_has_dots & ~line_mb_seen;
        vert_inc   = line_has_dots & line_vb_open;
        side_next  = (side_inc && side_cnt != CNT_MAX) ? side_cnt + 9'd1 : side_cnt;
        vert_next  = (vert_inc && vert_cnt != CNT_MAX) ? vert_cnt + 9'd1 : vert_cnt;
    end

    // line_has_dots is only raised by a line start, so a line cut by reset
    // keeps it low until the next new_line and is never counted.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            line_has_dots   <= 1'b0;
            line_mb_seen    <= 1'b0;
            line_vb_open    <= 1'b0;
            side_cnt        <= 9'd0;
            vert_cnt        <= 9'd0;
            open_side_lines <= 9'd0;
            open_vert_lines <= 9'd0;
        end else if (dot_rising) begin
            if (line_start) begin
                // Finalize the previous line, then start tracking with this dot.
                line_has_dots <= 1'b1;
                line_mb_seen  <= main_border;
                line_vb_open  <= ~vborder;
                if (new_frame) begin
                    open_side_lines <= side_next;
                    open_vert_lines <= vert_next;
                    side_cnt        <= 9'd0;
                    vert_cnt        <= 9'd0;
                end else begin
                    side_cnt <= side_next;
                    vert_cnt <= vert_next;
                end
            end else begin
                line_mb_seen <= line_mb_seen | main_border;
                line_vb_open <= line_vb_open | ~vborder;
            end
        end
    end

endmodule

// File: tb/tb_border_pixel_mux.sv
module tb_border_pixel_mux;

    logic       clk_dot4x = 1'b0;
    logic       rst = 1'b1;
    logic       dot_rising = 1'b0;
    logic       main_border = 1'b1;
    logic       vborder = 1'b1;
    logic [3:0] ec = 4'd0;
    logic [3:0] pixel_color_in = 4'd0;
    logic       new_line = 1'b0;
    logic       new_frame = 1'b0;

    logic [3:0] po1, po2, po4;
    logic       ba1, ba2, ba4;
    logic [8:0] side1, side2, side4;
    logic [8:0] vert1, vert2, vert4;

    int checks = 0;
    int failures = 0;

    always #5 clk_dot4x = ~clk_dot4x;

    border_pixel_mux #(.PIPE_DEPTH(1)) u_d1 (
        .clk_dot4x(clk_dot4x), .rst(rst), .dot_rising(dot_rising),
        .main_border(main_border), .vborder(vborder), .ec(ec),
        .pixel_color_in(pixel_color_in), .new_line(new_line), .new_frame(new_frame),
        .pixel_color_out(po1), .border_active(ba1),
        .open_side_lines(side1), .open_vert_lines(vert1));

    border_pixel_mux #(.PIPE_DEPTH(2)) u_d2 (
        .clk_dot4x(clk_dot4x), .rst(rst), .dot_rising(dot_rising),
        .main_border(main_border), .vborder(vborder), .ec(ec),
        .pixel_color_in(pixel_color_in), .new_line(new_line), .new_frame(new_frame),
        .pixel_color_out(po2), .border_active(ba2),
        .open_side_lines(side2), .open_vert_lines(vert2));

    border_pixel_mux #(.PIPE_DEPTH(4)) u_d4 (
        .clk_dot4x(clk_dot4x), .rst(rst), .dot_rising(dot_rising),
        .main_border(main_border), .vborder(vborder), .ec(ec),
        .pixel_color_in(pixel_color_in), .new_line(new_line), .new_frame(new_frame),
        .pixel_color_out(po4), .border_active(ba4),
        .open_side_lines(side4), .open_vert_lines(vert4));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Three idle cycles, then one dot edge; returns 1 time unit after the edge.
    task automatic dot();
        repeat (3) @(posedge clk_dot4x);
        #1 dot_rising = 1'b1;
        @(posedge clk_dot4x);
        #1 dot_rising = 1'b0;
    endtask

    // One raster line of n dots; vborder drops on the last dot when vb_open.
    task automatic send_line(input logic mb, input logic vb_open, input int n);
        for (int i = 0; i < n; i++) begin
            new_line    = (i == 0);
            main_border = mb;
            vborder     = (vb_open && i == n - 1) ? 1'b0 : 1'b1;
            dot();
        end
        new_line = 1'b0;
        vborder  = 1'b1;
    endtask

    // First dot of a new frame; that dot starts a closed, non-vert-open line.
    task automatic frame_mark();
        new_line    = 1'b1;
        new_frame   = 1'b1;
        main_border = 1'b1;
        vborder     = 1'b1;
        dot();
        new_line  = 1'b0;
        new_frame = 1'b0;
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk_dot4x);
        #1;
        chk("rst_po2", po2, 0);
        chk("rst_ba2", ba2, 1);
        chk("rst_side", side2, 0);
        chk("rst_vert", vert2, 0);
        rst = 1'b0;

        // first samples after reset: reset stages drain first
        main_border    = 1'b0;
        ec             = 4'd14;
        pixel_color_in = 4'd5;
        for (int k = 1; k <= 5; k++) begin
            dot();
            chk($sformatf("lat_po1_e%0d", k), po1, (k > 1) ? 5 : 0);
            chk($sformatf("lat_po2_e%0d", k), po2, (k > 2) ? 5 : 0);
            chk($sformatf("lat_ba2_e%0d", k), ba2, (k > 2) ? 0 : 1);
            chk($sformatf("lat_po4_e%0d", k), po4, (k > 4) ? 5 : 0);
        end

        // outputs hold between dots
        pixel_color_in = 4'd9;
        repeat (2) @(posedge clk_dot4x);
        #1;
        chk("hold_po2", po2, 5);
        chk("hold_po1", po1, 5);
        dot();
        chk("pix_po1", po1, 9);
        chk("pix_po2", po2, 9);

        // ec change mid-border: 6 -> 2 at dot n
        main_border = 1'b1;
        ec          = 4'd6;
        repeat (5) dot();
        chk("ec_pre_po4", po4, 6);
        chk("ec_pre_ba4", ba4, 1);
        ec = 4'd2;
        for (int j = 0; j <= 5; j++) begin
            dot();
            chk($sformatf("ec_po1_n%0d", j), po1, (j >= 1) ? 2 : 6);
            chk($sformatf("ec_po2_n%0d", j), po2, (j >= 2) ? 2 : 6);
            chk($sformatf("ec_po4_n%0d", j), po4, (j >= 4) ? 2 : 6);
        end

        // 3 side-open lines + 2 normal lines, each vert-open
        frame_mark();
        send_line(1'b0, 1'b1, 3);
        send_line(1'b0, 1'b1, 2);
        send_line(1'b0, 1'b1, 4);
        send_line(1'b1, 1'b1, 3);
        send_line(1'b1, 1'b1, 2);
        frame_mark();
        chk("mix_side", side2, 3);
        chk("mix_vert", vert2, 5);

        // reset mid-line after 2 open lines
        pixel_color_in = 4'd5;
        send_line(1'b0, 1'b1, 2);
        send_line(1'b0, 1'b1, 2);
        new_line    = 1'b1;
        main_border = 1'b0;
        dot();
        new_line = 1'b0;
        dot();
        chk("prerst_po2", po2, 5);
        chk("prerst_side", side2, 3);
        rst = 1'b1;
        dot();
        chk("inrst_po2", po2, 0);
        chk("inrst_ba2", ba2, 1);
        chk("inrst_side", side2, 0);
        chk("inrst_vert", vert2, 0);
        rst = 1'b0;
        main_border = 1'b0;
        vborder     = 1'b0;
        repeat (2) dot();
        vborder = 1'b1;
        send_line(1'b0, 1'b1, 2);
        frame_mark();
        chk("rstline_side", side2, 1);
        chk("rstline_vert", vert2, 1);

        // saturation at 511, then a frame with nothing open
        for (int i = 0; i < 600; i++) send_line(1'b0, 1'b1, 1);
        frame_mark();
        chk("sat_side", side2, 511);
        chk("sat_vert", vert2, 511);
        for (int i = 0; i < 4; i++) send_line(1'b1, 1'b0, 2);
        frame_mark();
        chk("zero_side", side2, 0);
        chk("zero_vert", vert2, 0);

        // new_line pulse between dots must not split the line
        new_line    = 1'b1;
        main_border = 1'b0;
        dot();
        new_line = 1'b0;
        @(posedge clk_dot4x);
        #1 new_line = 1'b1;
        @(posedge clk_dot4x);
        #1 new_line = 1'b0;
        repeat (2) dot();
        frame_mark();
        chk("offdot_side", side2, 1);
        chk("offdot_vert", vert2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
